// File: rtl/raisin64_mem_pkg.sv
`default_nettype none
// ============================================================================
// Module  : raisin64_mem_pkg
// Brief   : Shared width codes, bridge state encoding and alignment helper
// Revision: 1.0 - initial release
// ============================================================================
package raisin64_mem_pkg;

  typedef enum logic [1:0] {
    W64 = 2'd0,
    W32 = 2'd1,
    W16 = 2'd2,
    W8  = 2'd3
  } width_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BEAT0 = 2'd1,
    ST_BEAT1 = 2'd2,
    ST_DONE  = 2'd3
  } bridge_state_e;

  function automatic logic is_aligned(input width_e w, input logic [2:0] a);
    logic r_ok;
    r_ok = 1'b1;
    unique case (w)
      W64:     r_ok = (a == 3'b000);
      W32:     r_ok = (a[1:0] == 2'b00);
      W16:     r_ok = ~a[0];
      default: r_ok = 1'b1;
    endcase
    return r_ok;
  endfunction

endpackage
`default_nettype wire

// File: rtl/dmem_lane_mux.sv
`default_nettype none
// ============================================================================
// Module  : dmem_lane_mux
// Brief   : Big-endian byte-enable, store replication and load justification
// Revision: 1.0 - initial release
// ============================================================================
module dmem_lane_mux
  import raisin64_mem_pkg::*;
(
  input  width_e      width,
  input  logic [1:0]  addr_lo,
  input  logic [63:0] sdata,
  input  logic        second_beat,
  input  logic [31:0] rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata,
  output logic [63:0] rlane
);

  always_comb begin
    be    = 4'b0000;
    wdata = 32'h0;
    rlane = 64'h0;
    unique case (width)
      W8: begin
        be    = 4'b1000 >> addr_lo;
        wdata = {4{sdata[7:0]}};
        unique case (addr_lo)
          2'd0:    rlane[63:56] = rdata[31:24];
          2'd1:    rlane[63:56] = rdata[23:16];
          2'd2:    rlane[63:56] = rdata[15:8];
          default: rlane[63:56] = rdata[7:0];
        endcase
      end
      W16: begin
        be           = addr_lo[1] ? 4'b0011 : 4'b1100;
        wdata        = {2{sdata[15:0]}};
        rlane[63:48] = addr_lo[1] ? rdata[15:0] : rdata[31:16];
      end
      W32: begin
        be    = 4'b1111;
        wdata = sdata[31:0];
        rlane = {rdata, 32'h0};
      end
      default: begin
        // 64-bit: high word goes out first, low word on the second beat
        be    = 4'b1111;
        wdata = second_beat ? sdata[31:0] : sdata[63:32];
        rlane = {rdata, 32'h0};
      end
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/dmem_bridge32.sv
`default_nettype none
// ============================================================================
// Module  : dmem_bridge32
// Brief   : 64-bit data-memory request port onto 32-bit big-endian bus
// Revision: 1.0 - initial release
// ============================================================================
module dmem_bridge32
  import raisin64_mem_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [63:0] dmem_addr,
  input  logic [63:0] dmem_dout,
  input  logic [1:0]  dmem_width,
  input  logic        dmem_rstrobe,
  input  logic        dmem_wstrobe,
  output logic [63:0] dmem_din,
  output logic        dmem_cycle_complete,
  output logic        dmem_fault,
  output logic [63:0] mem_addr,
  output logic        mem_req,
  output logic        mem_we,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack
);

  localparam int c_CNT_W = $clog2(TIMEOUT_CYCLES + 2);
  localparam logic [c_CNT_W-1:0] c_CNT_ONE = 1;

  bridge_state_e       r_state;
  bridge_state_e       w_next;
  logic [63:0]         r_addr;
  logic [63:0]         r_sdata;
  width_e              r_width;
  logic                r_is_read;
  logic [31:0]         r_rhi;
  logic [c_CNT_W-1:0]  r_cnt;

  logic                w_strobe;
  logic                w_aligned;
  logic                w_timeout;
  logic                w_idle;
  width_e              w_mux_width;
  logic [1:0]          w_mux_lo;
  logic [63:0]         w_mux_sdata;
  logic [3:0]          w_be;
  logic [31:0]         w_wdata;
  logic [63:0]         w_rlane;

  assign w_strobe  = dmem_rstrobe | dmem_wstrobe;
  assign w_aligned = is_aligned(width_e'(dmem_width), dmem_addr[2:0]);
  assign w_timeout = (TIMEOUT_CYCLES != 0) &&
                     (32'(r_cnt) == 32'(TIMEOUT_CYCLES - 1));

  // In IDLE the mux sees the live request so the first beat is set up on the strobe edge
  assign w_idle      = (r_state == ST_IDLE);
  assign w_mux_width = w_idle ? width_e'(dmem_width) : r_width;
  assign w_mux_lo    = w_idle ? dmem_addr[1:0] : r_addr[1:0];
  assign w_mux_sdata = w_idle ? dmem_dout : r_sdata;

  dmem_lane_mux u_lane_mux (
    .width       (w_mux_width),
    .addr_lo     (w_mux_lo),
    .sdata       (w_mux_sdata),
    .second_beat (r_state == ST_BEAT0),
    .rdata       (mem_rdata),
    .be          (w_be),
    .wdata       (w_wdata),
    .rlane       (w_rlane)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      ST_IDLE: begin
        if (w_strobe) w_next = w_aligned ? ST_BEAT0 : ST_DONE;
      end
      ST_BEAT0: begin
        if (mem_ack)        w_next = (r_width == W64) ? ST_BEAT1 : ST_DONE;
        else if (w_timeout) w_next = ST_DONE;
      end
      ST_BEAT1: begin
        if (mem_ack || w_timeout) w_next = ST_DONE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dmem_din            <= 64'h0;
      dmem_cycle_complete <= 1'b0;
      dmem_fault          <= 1'b0;
      mem_addr            <= 64'h0;
      mem_req             <= 1'b0;
      mem_we              <= 1'b0;
      mem_be              <= 4'b0000;
      mem_wdata           <= 32'h0;
      r_addr              <= 64'h0;
      r_sdata             <= 64'h0;
      r_width             <= W64;
      r_is_read           <= 1'b0;
      r_rhi               <= 32'h0;
      r_cnt               <= '0;
    end else begin
      dmem_cycle_complete <= 1'b0;
      dmem_fault          <= 1'b0;
      unique case (r_state)
        ST_IDLE: begin
          if (w_strobe) begin
            r_addr    <= dmem_addr;
            r_sdata   <= dmem_dout;
            r_width   <= width_e'(dmem_width);
            r_is_read <= dmem_rstrobe;
            r_cnt     <= '0;
            if (w_aligned) begin
              mem_req   <= 1'b1;
              mem_we    <= ~dmem_rstrobe;
              mem_addr  <= {dmem_addr[63:2], 2'b00};
              mem_be    <= w_be;
              mem_wdata <= w_wdata;
            end else begin
              dmem_cycle_complete <= 1'b1;
              dmem_fault          <= 1'b1;
              if (dmem_rstrobe) dmem_din <= 64'h0;
            end
          end
        end
        ST_BEAT0: begin
          if (mem_ack) begin
            r_cnt <= '0;
            if (r_width == W64) begin
              r_rhi     <= mem_rdata;
              mem_addr  <= {r_addr[63:2], 2'b00} + 64'd4;
              mem_wdata <= w_wdata;
            end else begin
              mem_req             <= 1'b0;
              mem_we              <= 1'b0;
              dmem_cycle_complete <= 1'b1;
              if (r_is_read) dmem_din <= w_rlane;
            end
          end else if (w_timeout) begin
            mem_req             <= 1'b0;
            mem_we              <= 1'b0;
            dmem_cycle_complete <= 1'b1;
            dmem_fault          <= 1'b1;
            if (r_is_read) dmem_din <= 64'h0;
          end else begin
            r_cnt <= r_cnt + c_CNT_ONE;
          end
        end
        ST_BEAT1: begin
          if (mem_ack || w_timeout) begin
            mem_req             <= 1'b0;
            mem_we              <= 1'b0;
            dmem_cycle_complete <= 1'b1;
            dmem_fault          <= ~mem_ack;
            // A timeout on the second beat discards the first word as well
            if (r_is_read) dmem_din <= mem_ack ? {r_rhi, mem_rdata} : 64'h0;
          end else begin
            r_cnt <= r_cnt + c_CNT_ONE;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dmem_bridge32.sv
`default_nettype none
// ============================================================================
// Module  : tb_dmem_bridge32
// Brief   : Randomized self-checking bench for dmem_bridge32
// Revision: 1.0 - initial release
// ============================================================================
module tb_dmem_bridge32;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [63:0] dmem_addr;
  logic [63:0] dmem_dout;
  logic [1:0]  dmem_width;
  logic        dmem_rstrobe;
  logic        dmem_wstrobe;
  logic [63:0] dmem_din;
  logic        dmem_cycle_complete;
  logic        dmem_fault;
  logic [63:0] mem_addr;
  logic        mem_req;
  logic        mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [63:0] exp_din  = 64'h0;

  dmem_bridge32 #(.TIMEOUT_CYCLES(TO)) dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .dmem_addr           (dmem_addr),
    .dmem_dout           (dmem_dout),
    .dmem_width          (dmem_width),
    .dmem_rstrobe        (dmem_rstrobe),
    .dmem_wstrobe        (dmem_wstrobe),
    .dmem_din            (dmem_din),
    .dmem_cycle_complete (dmem_cycle_complete),
    .dmem_fault          (dmem_fault),
    .mem_addr            (mem_addr),
    .mem_req             (mem_req),
    .mem_we              (mem_we),
    .mem_be              (mem_be),
    .mem_wdata           (mem_wdata),
    .mem_rdata           (mem_rdata),
    .mem_ack             (mem_ack)
  );

  always #5 clk = ~clk;

  task automatic chk_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [1:0] wcode(input int n);
    return (n == 8) ? 2'd0 : (n == 4) ? 2'd1 : (n == 2) ? 2'd2 : 2'd3;
  endfunction

  // Lanes covered by an n-byte access; bit 3 is word offset 0
  function automatic logic [3:0] ref_be(input int n, input logic [63:0] a);
    logic [3:0] r;
    int o;
    r = 4'b0000;
    o = (n >= 4) ? 0 : int'(a[1:0]);
    for (int i = 0; i < 4; i++)
      if (i >= o && i < o + n) r[3-i] = 1'b1;
    return r;
  endfunction

  function automatic logic [31:0] ref_wdata(input int n, input logic [63:0] d, input int b);
    logic [63:0] v;
    logic [63:0] r;
    if (n == 8) return (b == 0) ? d[63:32] : d[31:0];
    v = d & ((64'd1 << (8 * n)) - 64'd1);
    r = 64'h0;
    for (int k = 0; k < 4 / n; k++) r = (r << (8 * n)) | v;
    return r[31:0];
  endfunction

  // Big-endian byte stream from the bus words, value MSB-justified into 64 bits
  function automatic logic [63:0] ref_load(input int n, input logic [63:0] a,
                                           input logic [31:0] w0, input logic [31:0] w1);
    logic [7:0]  by [8];
    logic [63:0] v;
    int o;
    for (int i = 0; i < 4; i++) begin
      by[i]     = w0[31 - 8 * i -: 8];
      by[4 + i] = w1[31 - 8 * i -: 8];
    end
    o = (n == 8) ? 0 : int'(a[1:0]);
    v = 64'h0;
    for (int i = 0; i < n; i++) v = (v << 8) | {56'h0, by[o + i]};
    return v << (64 - 8 * n);
  endfunction

  task automatic run_access(input bit rd, input int n, input logic [63:0] addr,
                            input logic [63:0] dout, input int ws,
                            input logic [31:0] rd0, input logic [31:0] rd1,
                            input int noack_beat);
    int          nbeats;
    logic [31:0] words [2];
    logic [63:0] base;
    nbeats   = (n == 8) ? 2 : 1;
    words[0] = rd0;
    words[1] = rd1;
    base     = {addr[63:2], 2'b00};
    dmem_addr    = addr;
    dmem_dout    = dout;
    dmem_width   = wcode(n);
    dmem_rstrobe = rd;
    dmem_wstrobe = !rd || ($urandom_range(3) == 0);
    tick();
    dmem_rstrobe = 1'b0;
    dmem_wstrobe = 1'b0;
    if ((int'(addr[2:0]) % n) != 0) begin
      chk_val("misal_req", mem_req, 0);
      chk_val("misal_cmp", dmem_cycle_complete, 1);
      chk_val("misal_flt", dmem_fault, 1);
      if (rd) exp_din = 64'h0;
      chk_val("misal_din", dmem_din, exp_din);
      tick();
      chk_val("misal_cmp_end", dmem_cycle_complete, 0);
      return;
    end
    for (int b = 0; b < nbeats; b++) begin
      int wlen;
      wlen = (b == noack_beat) ? TO : ws + 1;
      for (int w = 0; w < wlen; w++) begin
        chk_val("req", mem_req, 1);
        chk_val("we", mem_we, !rd);
        chk_val("addr", mem_addr, base + 64'(4 * b));
        chk_val("be", mem_be, ref_be(n, addr));
        if (!rd) chk_val("wdata", mem_wdata, ref_wdata(n, dout, b));
        chk_val("busy_cmp", dmem_cycle_complete, 0);
        if (w == 0 && $urandom_range(1) == 1) dmem_wstrobe = 1'b1;
        mem_rdata = $urandom;
        if (b != noack_beat && w == ws) begin
          mem_rdata = words[b];
          mem_ack   = 1'b1;
        end
        tick();
        mem_ack      = 1'b0;
        dmem_wstrobe = 1'b0;
      end
      if (b == noack_beat) begin
        chk_val("to_req", mem_req, 0);
        chk_val("to_cmp", dmem_cycle_complete, 1);
        chk_val("to_flt", dmem_fault, 1);
        if (rd) exp_din = 64'h0;
        chk_val("to_din", dmem_din, exp_din);
        tick();
        chk_val("to_cmp_end", dmem_cycle_complete, 0);
        return;
      end
    end
    chk_val("cmp", dmem_cycle_complete, 1);
    chk_val("flt", dmem_fault, 0);
    chk_val("req_end", mem_req, 0);
    if (rd) exp_din = ref_load(n, addr, words[0], words[1]);
    chk_val("din", dmem_din, exp_din);
    tick();
    chk_val("cmp_end", dmem_cycle_complete, 0);
  endtask

  initial begin
    rst_n        = 1'b0;
    dmem_addr    = 64'h0;
    dmem_dout    = 64'h0;
    dmem_width   = 2'd0;
    dmem_rstrobe = 1'b0;
    dmem_wstrobe = 1'b0;
    mem_rdata    = 32'h0;
    mem_ack      = 1'b0;
    #23;
    chk_val("rst_din", dmem_din, 0);
    chk_val("rst_cmp", dmem_cycle_complete, 0);
    chk_val("rst_flt", dmem_fault, 0);
    chk_val("rst_req", mem_req, 0);
    chk_val("rst_we", mem_we, 0);
    chk_val("rst_be", mem_be, 0);
    chk_val("rst_addr", mem_addr, 0);
    chk_val("rst_wdata", mem_wdata, 0);
    rst_n = 1'b1;
    tick();

    run_access(0, 1, 64'h1001, 64'hAB, 0, 32'h0, 32'h0, -1);
    run_access(1, 2, 64'h2002, 64'h0, 0, 32'h1234BEEF, 32'h0, -1);
    chk_val("ld16_din", dmem_din, 64'hBEEF000000000000);
    run_access(1, 8, 64'h3000, 64'h0, 2, 32'h01234567, 32'h89ABCDEF, -1);
    chk_val("ld64_din", dmem_din, 64'h0123456789ABCDEF);
    run_access(1, 4, 64'h4002, 64'h0, 0, 32'h0, 32'h0, -1);
    chk_val("misal_din0", dmem_din, 64'h0);
    run_access(1, 1, 64'h4003, 64'h0, 1, 32'hCAFEF00D, 32'h0, -1);
    run_access(0, 4, 64'h6000, 64'hDEADBEEF, 0, 32'h0, 32'h0, 0);
    run_access(0, 2, 64'h6006, 64'h5A5A, 3, 32'h0, 32'h0, -1);
    run_access(1, 8, 64'h7000, 64'h0, 1, 32'h11111111, 32'h22222222, 1);

    // ack while idle must not start or complete anything
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    chk_val("idle_ack_cmp", dmem_cycle_complete, 0);
    chk_val("idle_ack_req", mem_req, 0);

    for (int t = 0; t < 40; t++) begin
      int          n;
      logic [63:0] a;
      n = 1 << $urandom_range(3);
      a = {$urandom, $urandom};
      if ($urandom_range(3) != 0) a = a & ~64'(n - 1);
      run_access($urandom_range(1) == 1, n, a, {$urandom, $urandom},
                 $urandom_range(TO - 1), $urandom, $urandom,
                 ($urandom_range(7) == 0) ? $urandom_range(n == 8 ? 1 : 0) : -1);
    end

    // reset during the second beat of a 64-bit store
    dmem_addr    = 64'h5000;
    dmem_dout    = 64'hA5A5A5A5_5A5A5A5A;
    dmem_width   = 2'd0;
    dmem_wstrobe = 1'b1;
    tick();
    dmem_wstrobe = 1'b0;
    mem_ack      = 1'b1;
    tick();
    chk_val("rb1_req", mem_req, 1);
    chk_val("rb1_addr", mem_addr, 64'h5004);
    chk_val("rb1_wdata", mem_wdata, 32'h5A5A5A5A);
    rst_n = 1'b0;
    #1;
    chk_val("rb_req", mem_req, 0);
    chk_val("rb_we", mem_we, 0);
    chk_val("rb_be", mem_be, 0);
    chk_val("rb_addr", mem_addr, 0);
    chk_val("rb_wdata", mem_wdata, 0);
    chk_val("rb_din", dmem_din, 0);
    chk_val("rb_cmp", dmem_cycle_complete, 0);
    #3;
    rst_n   = 1'b1;
    exp_din = 64'h0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_val("post_rst_cmp", dmem_cycle_complete, 0);
      chk_val("post_rst_req", mem_req, 0);
      mem_ack = 1'b0;
    end
    run_access(1, 4, 64'h8004, 64'h0, 1, 32'h76543210, 32'h0, -1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
